// File: rtl/mmio_timer_if.sv
// MMIO bus bundle between the CPU MEM stage and the timer.
// master = CPU side, slave = timer side (decode, read data, irq).
interface mmio_timer_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        sel;
  logic        irq;

  modport master (
    output memwrite,
    output memaddr,
    output memwritedata,
    input  memreaddata,
    input  sel,
    input  irq
  );

  modport slave (
    input  memwrite,
    input  memaddr,
    input  memwritedata,
    output memreaddata,
    output sel,
    output irq
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped timer: CTRL/COUNT/COMPARE/STATUS in a 16-byte window.
// Ports: clk, reset (async, active-low), bus (slave side), irq via bus.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic         clk,
  input  logic         reset,
  mmio_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_COUNT = 2'd1,
    REG_CMP   = 2'd2,
    REG_STAT  = 2'd3
  } reg_e;

  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic        irqen_q, irqen_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  psc_q, psc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        ovf_q, ovf_d;

  logic        sel;
  logic        wr;
  reg_e        off;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_cmp;
  logic        wr_stat;
  logic        tick;
  logic        hit_cmp;
  logic        hit_ovf;
  logic [31:0] wdata;
  logic [31:0] rdata;

  // Byte lanes and upper CTRL/STATUS bits have no storage.
  logic unused_bits;
  assign unused_bits = ^{bus.memaddr[1:0],
                         wdata[31:16],
                         wdata[7:3]};

  assign wdata = bus.memwritedata;
  assign sel   = bus.memaddr[31:4] == BASE_ADDR[31:4];
  assign wr    = bus.memwrite & sel;
  assign off   = reg_e'(bus.memaddr[3:2]);

  always_comb begin
    wr_ctrl  = 1'b0;
    wr_count = 1'b0;
    wr_cmp   = 1'b0;
    wr_stat  = 1'b0;
    unique case (1'b1)
      (off == REG_CTRL):  wr_ctrl  = wr;
      (off == REG_COUNT): wr_count = wr;
      (off == REG_CMP):   wr_cmp   = wr;
      (off == REG_STAT):  wr_stat  = wr;
      default: ;
    endcase
  end

  // Tick and flag events are judged on pre-edge COUNT.
  assign tick    = en_q & (psc_q == presc_q);
  assign hit_cmp = tick & (count_q == cmp_q);
  assign hit_ovf = tick & (&count_q);

  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    irqen_d = irqen_q;
    presc_d = presc_q;
    psc_d   = psc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    ovf_d   = ovf_q;

    if (!en_q || tick) begin
      psc_d = 8'd0;
    end else begin
      psc_d = psc_q + 8'd1;
    end

    if (wr_ctrl) begin
      en_d    = wdata[0];
      ar_d    = wdata[1];
      irqen_d = wdata[2];
      presc_d = wdata[15:8];
      if (!wdata[0]) begin
        psc_d = 8'd0;
      end
    end

    // All-ones + 1 wraps to 0, covering overflow.
    if (tick) begin
      if (hit_cmp && ar_q) begin
        count_d = 32'd0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // CPU store beats the tick increment.
    if (wr_count) begin
      count_d = wdata;
    end

    if (wr_cmp) begin
      cmp_d = wdata;
    end

    // W1C, with a same-edge set taking priority.
    match_d = (match_q & ~(wr_stat & wdata[0])) | hit_cmp;
    ovf_d   = (ovf_q & ~(wr_stat & wdata[1])) | hit_ovf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      irqen_q <= 1'b0;
      presc_q <= 8'd0;
      psc_q   <= 8'd0;
      count_q <= 32'd0;
      cmp_q   <= 32'd0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      irqen_q <= irqen_d;
      presc_q <= presc_d;
      psc_q   <= psc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      unique case (off)
        REG_CTRL:  rdata = {16'd0, presc_q, 5'd0,
                            irqen_q, ar_q, en_q};
        REG_COUNT: rdata = count_q;
        REG_CMP:   rdata = cmp_q;
        REG_STAT:  rdata = {30'd0, ovf_q, match_q};
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign bus.memreaddata = rdata;
  assign bus.sel         = sel;
  assign bus.irq         = irqen_q & (match_q | ovf_q);

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: register table plus
// hand-written counting, overflow, collision and reset sequences.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_CNT  = BASE + 32'h4;
  localparam logic [31:0] A_CMP  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mmio_timer_if bus ();

  mmio_timer #(
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_sel;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    bus.memwrite     = 1'b1;
    bus.memaddr      = a;
    bus.memwritedata = d;
    @(negedge clk);
    bus.memwrite     = 1'b0;
  endtask

  task automatic rd(input  logic [31:0] a,
                    output logic [31:0] d);
    bus.memwrite = 1'b0;
    bus.memaddr  = a;
    #1;
    d = bus.memreaddata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.memwrite = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] r;
  logic [31:0] r2;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.memwrite     = 1'b0;
    bus.memaddr      = A_CNT;
    bus.memwritedata = 32'd0;

    vecs[0]  = '{1'b0, A_CTRL, 32'd0, 32'd0, 1'b1, "rst_ctrl"};
    vecs[1]  = '{1'b0, A_CNT,  32'd0, 32'd0, 1'b1, "rst_count"};
    vecs[2]  = '{1'b0, A_CMP,  32'd0, 32'd0, 1'b1, "rst_cmp"};
    vecs[3]  = '{1'b0, A_STAT, 32'd0, 32'd0, 1'b1, "rst_stat"};
    vecs[4]  = '{1'b1, A_CMP,  32'h1234_5678, 32'd0, 1'b1, "w_cmp"};
    vecs[5]  = '{1'b0, A_CMP,  32'd0, 32'h1234_5678, 1'b1, "r_cmp"};
    vecs[6]  = '{1'b0, BASE + 32'h10, 32'd0, 32'd0, 1'b0, "oob"};
    vecs[7]  = '{1'b0, BASE + 32'hB, 32'd0, 32'h1234_5678, 1'b1,
                 "lowbits"};
    vecs[8]  = '{1'b1, A_CTRL, 32'hFFFF_FF06, 32'd0, 1'b1, "w_ctrl"};
    vecs[9]  = '{1'b0, A_CTRL, 32'd0, 32'h0000_FF06, 1'b1, "r_ctrl"};
    vecs[10] = '{1'b1, A_CTRL, 32'd0, 32'd0, 1'b1, "w_ctrl0"};
    vecs[11] = '{1'b1, A_CNT,  32'd7, 32'd0, 1'b1, "w_cnt"};
    vecs[12] = '{1'b0, A_CNT,  32'd0, 32'd7, 1'b1, "r_cnt_hold"};
    vecs[13] = '{1'b0, 32'h0000_0008, 32'd0, 32'd0, 1'b0, "other_base"};
    vecs[14] = '{1'b1, A_STAT, 32'd3, 32'd0, 1'b1, "w_stat"};
    vecs[15] = '{1'b0, A_STAT, 32'd0, 32'd0, 1'b1, "r_stat"};

    // Reads during reset
    #12;
    rd(A_CNT, r);
    chk("in_reset_cnt", r, 32'd0);
    chk("in_reset_irq", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, r);
        chk(vecs[i].name, r, vecs[i].exp);
        chk({vecs[i].name, "_sel"}, {31'd0, bus.sel},
            {31'd0, vecs[i].exp_sel});
      end
    end

    // Match with autoreload, compare=3, presc=0
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h3);
    rd(A_CNT, r);
    chk("ar_cnt0", r, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      rd(A_CNT, r);
      chk($sformatf("ar_cnt%0d", k), r, 32'(k % 4));
      rd(A_STAT, r);
      chk($sformatf("ar_match%0d", k), r, (k >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("ar_irq%0d", k), {31'd0, bus.irq}, 32'd0);
    end

    // Prescaler 4: one increment per 5 cycles
    do_reset();
    wr(A_CTRL, 32'h0000_0401);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      rd(A_CNT, r);
      chk($sformatf("psc_cnt%0d", k), r, 32'(k / 5));
    end

    // Overflow with irq
    do_reset();
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h5);
    rd(A_CNT, r);
    chk("ovf_cnt0", r, 32'hFFFF_FFFE);
    @(negedge clk);
    rd(A_CNT, r);
    chk("ovf_cnt1", r, 32'hFFFF_FFFF);
    rd(A_STAT, r);
    chk("ovf_stat1", r, 32'd0);
    chk("ovf_irq1", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    rd(A_CNT, r);
    chk("ovf_cnt2", r, 32'd0);
    rd(A_STAT, r);
    chk("ovf_stat2", r, 32'd2);
    chk("ovf_irq2", {31'd0, bus.irq}, 32'd1);
    wr(A_STAT, 32'd2);
    rd(A_STAT, r);
    chk("ovf_clr_stat", r, 32'd0);
    chk("ovf_clr_irq", {31'd0, bus.irq}, 32'd0);
    rd(A_CNT, r);
    chk("ovf_cnt3", r, 32'd1);

    // COUNT write collides with tick
    do_reset();
    wr(A_CTRL, 32'h1);
    wr(A_CNT, 32'd100);
    rd(A_CNT, r);
    chk("coll_cnt", r, 32'd100);
    @(negedge clk);
    rd(A_CNT, r);
    chk("coll_cnt_next", r, 32'd101);

    // W1C match collides with new match (compare=1, autoreload)
    do_reset();
    wr(A_CMP, 32'd1);
    wr(A_CTRL, 32'h3);
    @(negedge clk);
    @(negedge clk);
    rd(A_STAT, r);
    chk("w1c_pre", r, 32'd1);
    @(negedge clk);
    rd(A_CNT, r);
    chk("w1c_cnt", r, 32'd1);
    wr(A_STAT, 32'd1);
    rd(A_STAT, r);
    chk("w1c_setwins", r, 32'd1);
    wr(A_STAT, 32'd1);
    rd(A_STAT, r);
    chk("w1c_clear", r, 32'd0);

    // Reset mid-operation with irq asserted
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h5);
    repeat (3) @(negedge clk);
    chk("mid_irq_pre", {31'd0, bus.irq}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_irq_rst", {31'd0, bus.irq}, 32'd0);
    rd(A_CNT, r);
    rd(A_CTRL, r2);
    chk("mid_cnt_rst", r, 32'd0);
    chk("mid_ctrl_rst", r2, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rd(A_CNT, r);
    rd(A_CTRL, r2);
    chk("mid_cnt_after", r, 32'd0);
    chk("mid_ctrl_after", r2, 32'd0);
    chk("mid_irq_after", {31'd0, bus.irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
